// File: rtl/spi_mc_pkg.sv
// Shared types, SPI mode constants and width helpers for the multi-channel SPI master.
package spi_mc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      XFER,
      TRAIL,
      GAP
   } state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   localparam logic CPOL_LOW    = 1'b0;
   localparam logic CPOL_HIGH   = 1'b1;
   localparam logic CPHA_FIRST  = 1'b0;
   localparam logic CPHA_SECOND = 1'b1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Select index needs at least one bit even for a single channel.
   function automatic int clog2_min1(input int n);
      int r;
      r = clog2(n);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/spi_hp_tick.sv
// Half-period timer: counts DIV..0 and flags the last cycle of each SCLK half-period.
module spi_hp_tick #(
   parameter int C_DIV_W = 8
) (
   input  logic               clk,
   input  logic               srst,
   input  logic               restart,
   input  logic [C_DIV_W-1:0] div,
   output logic               tick
);

   logic [C_DIV_W-1:0] cnt_q;
   logic [C_DIV_W-1:0] cnt_d;

   always_comb begin
      tick  = 1'b0;
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = div;
      end else if (cnt_q == '0) begin
         tick  = 1'b1;
         cnt_d = div;
      end else begin
         cnt_d = cnt_q - C_DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_master_mc.sv
// Multi-channel SPI master: shared SCLK/COPI, one active-low select and CIPO per channel,
// with channel, mode, divider and length chosen per transaction.
module spi_master_mc
   import spi_mc_pkg::*;
#(
   parameter int C_CH    = 3,
   parameter int C_W     = 16,
   parameter int C_DIV_W = 8
) (
   input  logic                          CK_i,
   input  logic                          RST_i,
   input  logic                          START_i,
   input  logic [clog2_min1(C_CH)-1:0]   CH_i,
   input  logic [clog2(C_W)-1:0]         LEN_i,
   input  logic                          CPOL_i,
   input  logic                          CPHA_i,
   input  logic [C_DIV_W-1:0]            DIV_i,
   input  logic [C_W-1:0]                TXD_i,
   output logic [C_W-1:0]                RXD_o,
   output logic                          BUSY_o,
   output logic                          DONE_o,
   output logic                          SCLK_o,
   output logic                          COPI_o,
   output logic [C_CH-1:0]               XSS_o,
   input  logic [C_CH-1:0]               CIPO_i
);

   localparam int CH_W  = clog2_min1(C_CH);
   localparam int LEN_W = clog2(C_W);
   localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(C_CH);

   state_t             state_q, state_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic               phase_q, phase_d;
   spi_mode_t          mode_q, mode_d;
   logic [C_DIV_W-1:0] div_q, div_d;
   logic [C_W-1:0]     tx_sr_q, tx_sr_d;
   logic [C_W-1:0]     rx_sr_q, rx_sr_d;
   logic [C_W-1:0]     rxd_q, rxd_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic               sclk_q, sclk_d;
   logic               copi_q, copi_d;
   logic [C_CH-1:0]    xss_q, xss_d;

   logic               sel_on_d;
   logic               ch_ok;
   logic [5:0]         shamt;
   logic [C_W-1:0]     tx_align;
   logic               cipo_bit;
   logic               hp_restart;
   logic [C_DIV_W-1:0] hp_load;
   logic               tick;

   assign hp_restart = (state_q == IDLE);
   assign hp_load    = (state_q == IDLE) ? DIV_i : div_q;

   spi_hp_tick #(
      .C_DIV_W (C_DIV_W)
   ) u_hp_tick (
      .clk     (CK_i),
      .srst    (RST_i),
      .restart (hp_restart),
      .div     (hp_load),
      .tick    (tick)
   );

   assign ch_ok    = ({1'b0, CH_i} < CH_LIMIT);
   // Left-align the LEN field so the next TX bit is always the register MSB.
   assign shamt    = 6'(C_W - 1) - 6'(LEN_i);
   assign tx_align = TXD_i << shamt;
   // Only the selected channel has its select low while bits are sampled.
   assign cipo_bit = |(CIPO_i & ~xss_q);

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      bit_cnt_d = bit_cnt_q;
      phase_d   = phase_q;
      mode_d    = mode_q;
      div_d     = div_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rxd_d     = rxd_q;
      done_d    = 1'b0;
      sclk_d    = sclk_q;
      copi_d    = copi_q;

      case (state_q)
         IDLE: begin
            sclk_d = CPOL_i;
            copi_d = 1'b0;
            if (START_i && ch_ok) begin
               state_d   = LEAD;
               ch_d      = CH_i;
               bit_cnt_d = LEN_i;
               phase_d   = 1'b0;
               mode_d    = '{cpol: CPOL_i, cpha: CPHA_i};
               div_d     = DIV_i;
               rx_sr_d   = '0;
               if (CPHA_i == CPHA_FIRST) begin
                  copi_d  = tx_align[C_W-1];
                  tx_sr_d = tx_align << 1;
               end else begin
                  tx_sr_d = tx_align;
               end
            end
         end
         LEAD: begin
            sclk_d = mode_q.cpol;
            if (tick) begin
               state_d = XFER;
               phase_d = 1'b0;
            end
         end
         XFER: begin
            if (tick) begin
               sclk_d  = ~sclk_q;
               phase_d = ~phase_q;
               if (!phase_q) begin
                  if (mode_q.cpha == CPHA_FIRST) begin
                     rx_sr_d = {rx_sr_q[C_W-2:0], cipo_bit};
                  end else begin
                     copi_d  = tx_sr_q[C_W-1];
                     tx_sr_d = tx_sr_q << 1;
                  end
               end else begin
                  if (mode_q.cpha == CPHA_SECOND) begin
                     rx_sr_d = {rx_sr_q[C_W-2:0], cipo_bit};
                  end else if (bit_cnt_q != '0) begin
                     copi_d  = tx_sr_q[C_W-1];
                     tx_sr_d = tx_sr_q << 1;
                  end
                  if (bit_cnt_q == '0) begin
                     state_d = TRAIL;
                  end else begin
                     bit_cnt_d = bit_cnt_q - LEN_W'(1);
                  end
               end
            end
         end
         TRAIL: begin
            sclk_d = mode_q.cpol;
            if (tick) begin
               state_d = GAP;
               rxd_d   = rx_sr_q;
               done_d  = 1'b1;
            end
         end
         GAP: begin
            if (tick) begin
               state_d = IDLE;
               copi_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      sel_on_d = (state_d == LEAD) || (state_d == XFER) || (state_d == TRAIL);
      busy_d   = (state_d != IDLE);
   end

   for (genvar gi = 0; gi < C_CH; gi++) begin : g_sel
      assign xss_d[gi] = ~(sel_on_d && (ch_d == CH_W'(gi)));
   end

   always_ff @(posedge CK_i) begin
      if (RST_i) begin
         state_q   <= IDLE;
         ch_q      <= '0;
         bit_cnt_q <= '0;
         phase_q   <= 1'b0;
         mode_q    <= '0;
         div_q     <= '0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rxd_q     <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         sclk_q    <= 1'b0;
         copi_q    <= 1'b0;
         xss_q     <= '1;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         bit_cnt_q <= bit_cnt_d;
         phase_q   <= phase_d;
         mode_q    <= mode_d;
         div_q     <= div_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rxd_q     <= rxd_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         sclk_q    <= sclk_d;
         copi_q    <= copi_d;
         xss_q     <= xss_d;
      end
   end

   assign RXD_o  = rxd_q;
   assign BUSY_o = busy_q;
   assign DONE_o = done_q;
   assign SCLK_o = sclk_q;
   assign COPI_o = copi_q;
   assign XSS_o  = xss_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: modes, channels, back-to-back, reset abort, extremes.
module tb_spi_master_mc;

   localparam int C_CH    = 3;
   localparam int C_W     = 16;
   localparam int C_DIV_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [1:0]        ch = '0;
   logic [3:0]        len = '0;
   logic              cpol = 1'b0;
   logic              cpha = 1'b0;
   logic [7:0]        div = '0;
   logic [15:0]       txd = '0;
   logic [15:0]       rxd;
   logic              busy, done, sclk, copi;
   logic [2:0]        xss;
   logic [2:0]        cipo;
   logic [7:0]        periph_pat = 8'h00;
   logic              periph_bit;

   int n_assert = 0;
   int n_fail   = 0;

   // statistics gathered by the monitor, restarted whenever clr_seq moves
   int clr_seq = 0, clr_seen = 0;
   int cyc = 0, busy_cnt = 0, done_cnt = 0, rise_cyc = 0;
   int sclk_edges = 0, sclk_falls = 0, multi_low = 0;
   int min_gap = 1000, hi_run = 0;
   int done_cyc [8];
   logic [31:0] copi_log = '0;
   logic [2:0]  xss_and = 3'b111;
   logic seen_low = 1'b0, prev_low = 1'b0, busy_prev = 1'b0, sclk_prev = 1'b0;

   always #5 clk = ~clk;

   // channel 1 peripheral shifts its pattern out MSB first, advancing on SCLK falls
   assign periph_bit = (sclk_falls < 8) ? periph_pat[3'(7 - sclk_falls)] : 1'b0;
   assign cipo = {1'b0, periph_bit, copi};

   spi_master_mc #(
      .C_CH    (C_CH),
      .C_W     (C_W),
      .C_DIV_W (C_DIV_W)
   ) dut (
      .CK_i    (clk),
      .RST_i   (rst),
      .START_i (start),
      .CH_i    (ch),
      .LEN_i   (len),
      .CPOL_i  (cpol),
      .CPHA_i  (cpha),
      .DIV_i   (div),
      .TXD_i   (txd),
      .RXD_o   (rxd),
      .BUSY_o  (busy),
      .DONE_o  (done),
      .SCLK_o  (sclk),
      .COPI_o  (copi),
      .XSS_o   (xss),
      .CIPO_i  (cipo)
   );

   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (clr_seq != clr_seen) begin
         clr_seen   = clr_seq;
         busy_cnt   = 0;
         done_cnt   = 0;
         rise_cyc   = 0;
         sclk_edges = 0;
         sclk_falls = 0;
         multi_low  = 0;
         min_gap    = 1000;
         hi_run     = 0;
         copi_log   = '0;
         xss_and    = 3'b111;
         seen_low   = 1'b0;
         prev_low   = 1'b0;
         busy_prev  = 1'b0;
      end
      if (busy) begin
         busy_cnt++;
         if (!busy_prev) rise_cyc = cyc;
      end
      busy_prev = busy;
      if (done) begin
         if (done_cnt < 8) done_cyc[done_cnt] = cyc;
         done_cnt++;
      end
      if (sclk !== sclk_prev) begin
         sclk_edges++;
         if (sclk) copi_log = {copi_log[30:0], copi};
         else      sclk_falls++;
      end
      sclk_prev = sclk;
      xss_and = xss_and & xss;
      if ($countones(~xss) > 1) multi_low++;
      if (xss == 3'b111) begin
         hi_run++;
      end else begin
         if (seen_low && !prev_low && hi_run < min_gap) min_gap = hi_run;
         seen_low = 1'b1;
         hi_run   = 0;
      end
      prev_low = (xss != 3'b111);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // configure, let SCLK settle to the new CPOL, then pulse START for one cycle
   task automatic launch(input logic [1:0] c, input logic [3:0] l, input logic po,
                         input logic ph, input logic [7:0] d, input logic [15:0] t);
      ch = c; len = l; cpol = po; cpha = ph; div = d; txd = t;
      repeat (2) @(negedge clk);
      clr_seq++;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int lim);
      for (int i = 0; i < lim && !(done_cnt > 0 && !busy); i++) @(negedge clk);
      check({tag, "_finished"}, 32'(done_cnt > 0 && !busy), 32'd1);
   endtask

   task automatic xfer(input string tag, input logic [1:0] c, input logic [3:0] l,
                       input logic po, input logic ph, input logic [7:0] d,
                       input logic [15:0] t, input logic [15:0] exp_rxd);
      int hp, exp_busy;
      hp       = int'(d) + 1;
      exp_busy = (2 * int'(l) + 5) * hp;
      launch(c, l, po, ph, d, t);
      check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      check({tag, "_xss_lead"}, 32'(xss), 32'(3'b111 & ~(3'b001 << c)));
      wait_done(tag, exp_busy + 20);
      check({tag, "_rxd"}, 32'(rxd), 32'(exp_rxd));
      check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_done_delay"}, done_cyc[0] - rise_cyc, (2 * int'(l) + 4) * hp);
      check({tag, "_sclk_edges"}, sclk_edges, 2 * (int'(l) + 1));
      check({tag, "_xss_used"}, 32'(xss_and), 32'(3'b111 & ~(3'b001 << c)));
      check({tag, "_one_select"}, multi_low, 0);
      check({tag, "_sclk_idle"}, 32'(sclk), 32'(po));
   endtask

   initial begin
      // reset with CPOL_i=1 so SCLK_o=0 proves the reset value wins
      cpol = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_xss", 32'(xss), 32'(3'b111));
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_copi", 32'(copi), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rxd", 32'(rxd), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_sclk_follows_cpol", 32'(sclk), 32'd1);

      // mode 0 on channel 1 against a peripheral returning 0x3C
      periph_pat = 8'h3C;
      xfer("m0", 2'd1, 4'd7, 1'b0, 1'b0, 8'd0, 16'h00A5, 16'h003C);
      check("m0_copi_bits", copi_log[7:0], 32'hA5);

      // modes 1..3, 16 bits, loopback on channel 0
      xfer("m1", 2'd0, 4'd15, 1'b0, 1'b1, 8'd3, 16'hC3A5, 16'hC3A5);
      xfer("m2", 2'd0, 4'd15, 1'b1, 1'b0, 8'd3, 16'hC3A5, 16'hC3A5);
      xfer("m3", 2'd0, 4'd15, 1'b1, 1'b1, 8'd3, 16'hC3A5, 16'hC3A5);

      // out-of-range channel must be ignored entirely
      launch(2'd3, 4'd7, 1'b0, 1'b0, 8'd0, 16'h00FF);
      check("badch_busy", 32'(busy), 32'd0);
      check("badch_xss", 32'(xss), 32'(3'b111));
      repeat (20) @(negedge clk);
      check("badch_busy_cycles", busy_cnt, 0);
      check("badch_done", done_cnt, 0);
      check("badch_xss_used", 32'(xss_and), 32'(3'b111));

      // START held: three back-to-back 4-bit transfers, upper TXD bits ignored
      ch = 2'd0; len = 4'd3; cpol = 1'b0; cpha = 1'b0; div = 8'd1; txd = 16'hFFFB;
      repeat (2) @(negedge clk);
      clr_seq++;
      start = 1'b1;
      for (int i = 0; i < 200 && done_cnt < 3; i++) @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      check("b2b_done_count", done_cnt, 3);
      check("b2b_busy_after", 32'(busy), 32'd0);
      check("b2b_spacing_1", done_cyc[1] - done_cyc[0], 23);
      check("b2b_spacing_2", done_cyc[2] - done_cyc[1], 23);
      check("b2b_busy_cycles", busy_cnt, 66);
      check("b2b_min_gap", min_gap, 3);
      check("b2b_rxd", 32'(rxd), 32'h000B);
      check("b2b_one_select", multi_low, 0);

      // reset while bit 4 of an 8-bit transfer is on the wire
      launch(2'd2, 4'd7, 1'b0, 1'b0, 8'd2, 16'h00FF);
      for (int i = 0; i < 200 && sclk_edges < 7; i++) @(negedge clk);
      check("abort_reached_bit4", 32'(sclk_edges >= 7), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_xss", 32'(xss), 32'(3'b111));
      check("abort_sclk", 32'(sclk), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_rxd", 32'(rxd), 32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_no_done", done_cnt, 0);
      check("abort_stays_idle", 32'(busy), 32'd0);
      xfer("post", 2'd0, 4'd7, 1'b0, 1'b0, 8'd0, 16'h005A, 16'h005A);

      // one-bit transfer at the slowest divider, mode 2
      xfer("slow", 2'd0, 4'd0, 1'b1, 1'b0, 8'd255, 16'h0001, 16'h0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
